picorv32_mem_arbiter: RTL and testbench
=======================================

// Module: picorv32_mem_arbiter
// PURPOSE
//  Shares one synchronous single-port word SRAM between two picorv32-style native memory masters.
//  m0 is the CPU; m1 is a loader/DMA/debug master.
//  Round-robin arbitration; one transaction in flight at a time.
//  Also decodes the console MMIO address and emits a byte strobe.
//  Sits between the core(s) and the memory / console in the SoC and the benches.
// PARAMETERS
//  MEM_WORDS     16384          SRAM depth in 32-bit words (64 KiB)
//  CONSOLE_ADDR  32'h1000_0000  byte address of the console output register
// PORTS
//  clk         in   1   clock
//  resetn      in   1   synchronous active-low reset
//  mN_valid    in   1   request from master N (N=0,1); held until mN_ready
//  mN_addr     in   32  byte address (bits [1:0] ignored)
//  mN_wdata    in   32  write data
//  mN_wstrb    in   4   byte write enables; 0 = read
//  mN_ready    out  1   single-cycle completion pulse
//  mN_rdata    out  32  read data; valid only while mN_ready=1
//  sram_en     out  1   SRAM access enable
//  sram_we     out  4   SRAM byte write enables
//  sram_addr   out  $clog2(MEM_WORDS)  word address
//  sram_wdata  out  32  SRAM write data
//  sram_rdata  in   32  SRAM read data, valid the cycle after sram_en
//  cons_valid  out  1   console byte strobe (ARB_CONSOLE_EN only)
//  cons_data   out  8   console byte (ARB_CONSOLE_EN only)
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  Reset values
//  - All outputs 0; state=IDLE; priority pointer favours m0.
//  FSM
//  - IDLE -> ACCESS: when any mN_valid is sampled.
//    - Grant goes to the sole requester, or, if both request, to the one not granted last.
//    - At the grant edge, latch addr/wdata/wstrb and the master id.
//  - ACCESS (1 cycle): registered sram_en=1, sram_we=wstrb, sram_addr=addr[..:2], sram_wdata.
//  - RESP (1 cycle): mN_ready=1 for the granted master only.
//    - mN_rdata = sram_rdata for reads, 0 for writes.
//    - Then unconditionally return to IDLE.
//  Timing
//  - valid sampled at edge t -> ready high during cycle t+2; max 1 transaction / 3 cycles.
//  - Masters deassert or change valid after ready; the arbiter never grants in RESP.
//  Address decode
//  - Out-of-range address (addr>>2 >= MEM_WORDS, not console):
//    - sram_en stays 0; reads return 0; writes are dropped.
//    - ready still pulses, so the master never hangs.
//  Other rules
//  - The non-granted master's valid is ignored until the next IDLE; its request is not lost.
//  - valid deasserted mid-transaction: the transaction still completes and ready still pulses.
//  - resetn low in any state: state->IDLE and outputs cleared at that edge; the in-flight write is aborted if still in IDLE/ACCESS edge.
//  - Starvation: with both masters continuously requesting, grants strictly alternate m0,m1,m0...
// CONFIGURATION
//  ARB_CONSOLE_EN defined
//  - Write (wstrb!=0) to CONSOLE_ADDR: no SRAM access.
//    - cons_valid=1 for exactly one cycle in the ACCESS cycle, cons_data=wdata[7:0].
//    - ready in RESP as normal.
//  - Read of CONSOLE_ADDR returns 0.
//  ARB_CONSOLE_EN undefined
//  - cons_valid/cons_data are tied 0.
//  - CONSOLE_ADDR is decoded as an ordinary (out-of-range) address.
// STRUCTURE
//  - Shared package picorv32_mem_pkg:
//    - state encoding localparams (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
//    - default CONSOLE_ADDR and MEM_WORDS constants
//  - Sub-module arb_rr2: 2-way round-robin grant plus last-grant pointer, registered; reused for other shared ports.
//  - Datapath request latch and FSM live in the top module.
// TESTING
//  1 Single read
//    - m0 reads 0x100 with mem[0x40]=32'hDEADBEEF.
//    - sram_en at t+1, sram_addr=0x40; m0_ready at t+2 with rdata=DEADBEEF.
//  2 Byte write
//    - m1 writes wdata=32'h11223344, wstrb=4'b0010 to 0x104.
//    - sram_we=0010, addr 0x41; m1_ready pulses one cycle; the word then holds byte1=0x33.
//  3 Contention
//    - Both valid continuously from reset for 4 transactions.
//    - Grant order m0,m1,m0,m1; each ready is one cycle; no ready to the wrong master.
//  4 Console
//    - ARB_CONSOLE_EN defined; m0 writes 0x41 to 0x1000_0000.
//    - cons_valid one cycle with cons_data=8'h41; sram_en stays 0.
//    - With the macro undefined: no cons_valid, ready still pulses.
//  5 Out of range
//    - m0 reads 0x0002_0000 (MEM_WORDS=16384).
//    - No sram_en; m0_ready at t+2 with rdata=0.
//  6 Reset mid-op
//    - Assert resetn=0 during ACCESS.
//    - Next cycle: state IDLE, all outputs 0, no ready pulse; the next request is granted to m0.

Source files
------------

// File: rtl/picorv32_mem_pkg.sv
// Shared types and defaults for the picorv32 memory arbiter.
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam int unsigned MEM_WORDS_DEFAULT    = 16384;
  localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h1000_0000;

  // True when the byte address falls inside an SRAM of mem_words 32-bit words.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned mem_words);
    return ({2'b00, addr[31:2]} < mem_words);
  endfunction

endpackage

// File: rtl/picorv32_mem_arbiter_if.sv
// picorv32-style native memory bus: one instance per master port.
interface picorv32_mem_arbiter_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/picorv32_mem_arbiter_arb_rr2.sv
// Two-way round-robin grant with a registered last-grant pointer.
// After reset the pointer says m1 was granted last, so m0 wins a tie.
module arb_rr2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_id
);
  logic last_q, last_d;

  // Grant the sole requester, or the one not granted last on a tie.
  always_comb begin
    gnt_id = (req == 2'b11) ? ~last_q : req[1];
    last_d = advance ? gnt_id : last_q;
  end

  // Last-grant pointer.
  always_ff @(posedge clk) begin
    if (!resetn) last_q <= 1'b1;
    else         last_q <= last_d;
  end
endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Shares one synchronous word SRAM between two native memory masters
// (m0 = CPU, m1 = loader/debug) with round-robin arbitration, one
// transaction in flight. Optional console byte strobe enabled by the
// ARB_CONSOLE_EN macro.
//
// state  | meaning
// IDLE   | waiting for a request; grants on the edge a valid is seen
// ACCESS | registered SRAM (or console) access is on the outputs
// RESP   | ready pulse to the granted master, rdata from SRAM for reads
module picorv32_mem_arbiter
  import picorv32_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = MEM_WORDS_DEFAULT,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT
) (
  input  logic                         clk,
  input  logic                         resetn,
  picorv32_mem_arbiter_if.slave        m0,
  picorv32_mem_arbiter_if.slave        m1,
  output logic                         sram_en,
  output logic [3:0]                   sram_we,
  output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
  output logic [31:0]                  sram_wdata,
  input  logic [31:0]                  sram_rdata,
  output logic                         cons_valid,
  output logic [7:0]                   cons_data,
  output logic                         busy
);
  localparam int AW = $clog2(MEM_WORDS);

  arb_state_e    state_q, state_d;
  logic          id_q, id_d;
  logic          rd_mem_q, rd_mem_d;
  logic [1:0]    ready_q, ready_d;
  logic          sram_en_q, sram_en_d;
  logic [3:0]    sram_we_q, sram_we_d;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]   sram_wdata_q, sram_wdata_d;
  logic          cons_valid_q, cons_valid_d;
  logic [7:0]    cons_data_q, cons_data_d;

  logic        grant_en;
  logic        gnt_id;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_is_cons;
  logic        sel_sram_hit;
  logic        unused_bits;

  assign grant_en = (state_q == IDLE) && (m0.valid || m1.valid);

  arb_rr2 u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req     ({m1.valid, m0.valid}),
    .advance (grant_en),
    .gnt_id  (gnt_id)
  );

  assign sel_addr  = gnt_id ? m1.addr  : m0.addr;
  assign sel_wdata = gnt_id ? m1.wdata : m0.wdata;
  assign sel_wstrb = gnt_id ? m1.wstrb : m0.wstrb;

`ifdef ARB_CONSOLE_EN
  assign sel_is_cons = (sel_addr[31:2] == CONSOLE_ADDR[31:2]);
  assign unused_bits = ^sel_addr[1:0];
`else
  // Console address falls through to the ordinary range decode.
  assign sel_is_cons = 1'b0;
  assign unused_bits = ^{sel_addr[1:0], CONSOLE_ADDR};
`endif

  assign sel_sram_hit = addr_in_range(sel_addr, MEM_WORDS) && !sel_is_cons;

  // Next-state and registered-output logic; grant, latch and SRAM drive happen on the IDLE edge.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    rd_mem_d     = rd_mem_q;
    ready_d      = 2'b00;
    sram_en_d    = 1'b0;
    sram_we_d    = 4'b0000;
    sram_addr_d  = '0;
    sram_wdata_d = 32'h0;
    cons_valid_d = 1'b0;
    cons_data_d  = 8'h00;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          state_d  = ACCESS;
          id_d     = gnt_id;
          rd_mem_d = sel_sram_hit && (sel_wstrb == 4'b0000);
          if (sel_sram_hit) begin
            sram_en_d    = 1'b1;
            sram_we_d    = sel_wstrb;
            sram_addr_d  = sel_addr[AW+1:2];
            sram_wdata_d = sel_wdata;
          end
          if (sel_is_cons && (sel_wstrb != 4'b0000)) begin
            cons_valid_d = 1'b1;
            cons_data_d  = sel_wdata[7:0];
          end
        end
      end
      ACCESS: begin
        state_d       = RESP;
        ready_d[id_q] = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      id_q         <= 1'b0;
      rd_mem_q     <= 1'b0;
      ready_q      <= 2'b00;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 4'b0000;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'h0;
      cons_valid_q <= 1'b0;
      cons_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      rd_mem_q     <= rd_mem_d;
      ready_q      <= ready_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      cons_valid_q <= cons_valid_d;
      cons_data_q  <= cons_data_d;
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign cons_valid = cons_valid_q;
  assign cons_data  = cons_data_q;
  assign busy       = (state_q != IDLE);

  // SRAM data arrives during RESP; pass it only to the granted master on an in-range read.
  assign m0.ready = ready_q[0];
  assign m1.ready = ready_q[1];
  assign m0.rdata = (ready_q[0] && rd_mem_q) ? sram_rdata : 32'h0;
  assign m1.rdata = (ready_q[1] && rd_mem_q) ? sram_rdata : 32'h0;
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
module tb_picorv32_mem_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  picorv32_mem_arbiter_if m0_if ();
  picorv32_mem_arbiter_if m1_if ();

  logic        sram_en;
  logic [3:0]  sram_we;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        busy;

  picorv32_mem_arbiter dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0         (m0_if),
    .m1         (m1_if),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .cons_valid (cons_valid),
    .cons_data  (cons_data),
    .busy       (busy)
  );

`ifdef ARB_CONSOLE_EN
  localparam bit CONS_EN = 1'b1;
`else
  localparam bit CONS_EN = 1'b0;
`endif

  typedef struct {
    bit          m;
    logic [31:0] rd;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          exp_en;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;
  vec_t vecs[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // SRAM model: registered read (old data), byte writes, known contents loaded during reset.
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (!resetn) begin
      mem[14'h0000] <= 32'h0102_0304;
      mem[14'h0040] <= 32'hDEAD_BEEF;
      mem[14'h0041] <= 32'hAABB_CCDD;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr];
    end
  end

  // Scoreboard: every ready pulse must match the oldest pending expectation.
  exp_t e;
  always @(negedge clk) begin
    if (m0_if.ready && m1_if.ready) begin
      tests++; fails++;
      $display("FAIL both_ready actual=11 required=one-hot");
    end
    if (m0_if.ready || m1_if.ready) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ready actual=m%0d required=none", m1_if.ready);
      end else begin
        e = sb_q.pop_front();
        check("sb_master", {31'b0, m1_if.ready}, {31'b0, e.m});
        check("sb_rdata", m1_if.ready ? m1_if.rdata : m0_if.rdata, e.rd);
      end
    end
    if (!CONS_EN && cons_valid) begin
      tests++; fails++;
      $display("FAIL cons_disabled actual=1 required=0");
    end
  end

  task automatic drive(input bit m, input bit v, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    if (!m) begin
      m0_if.valid = v; m0_if.addr = a; m0_if.wdata = wd; m0_if.wstrb = ws;
    end else begin
      m1_if.valid = v; m1_if.addr = a; m1_if.wdata = wd; m1_if.wstrb = ws;
    end
  endtask

  // One transaction from IDLE (called #1 after an edge); returns #1 after the edge back into IDLE.
  task automatic txn(input bit m, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input bit exp_en, input logic [31:0] exp_rd, input bit exp_cons, input string nm);
    drive(m, 1'b1, a, wd, ws);
    sb_q.push_back('{m, exp_rd});
    @(posedge clk); #1;
    check({nm, "_busy"}, {31'b0, busy}, 32'd1);
    check({nm, "_sram_en"}, {31'b0, sram_en}, {31'b0, exp_en});
    if (exp_en) begin
      check({nm, "_sram_addr"}, {18'b0, sram_addr}, {18'b0, a[15:2]});
      check({nm, "_sram_we"}, {28'b0, sram_we}, {28'b0, ws});
      if (ws != 4'b0000) check({nm, "_sram_wdata"}, sram_wdata, wd);
    end
    check({nm, "_cons_valid"}, {31'b0, cons_valid}, {31'b0, exp_cons});
    if (exp_cons) check({nm, "_cons_data"}, {24'b0, cons_data}, {24'b0, wd[7:0]});
    @(posedge clk); #1;
    check({nm, "_ready"}, {30'b0, m1_if.ready, m0_if.ready}, m ? 32'd2 : 32'd1);
    check({nm, "_cons_off"}, {31'b0, cons_valid}, 32'd0);
    drive(m, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check({nm, "_ready_done"}, {30'b0, m1_if.ready, m0_if.ready}, 32'd0);
    check({nm, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int cnt;
  initial begin
    vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,          4'b0000, 1'b1, 32'hDEAD_BEEF, "rd_100"});
    vecs.push_back('{1'b1, 32'h0000_0104, 32'h1122_3344,  4'b0010, 1'b1, 32'h0,         "wr_byte"});
    vecs.push_back('{1'b0, 32'h0000_0104, 32'h0,          4'b0000, 1'b1, 32'hAABB_33DD, "rd_104"});
    vecs.push_back('{1'b1, 32'h0000_0100, 32'h0,          4'b0000, 1'b1, 32'hDEAD_BEEF, "rd_m1"});
    vecs.push_back('{1'b0, 32'h0002_0000, 32'h0,          4'b0000, 1'b0, 32'h0,         "rd_oor"});
    vecs.push_back('{1'b1, 32'h0000_FFFC, 32'h5A5A_0001,  4'b1111, 1'b1, 32'h0,         "wr_top"});
    vecs.push_back('{1'b0, 32'h0000_FFFC, 32'h0,          4'b0000, 1'b1, 32'h5A5A_0001, "rd_top"});
    vecs.push_back('{1'b0, 32'h0001_0000, 32'hFFFF_FFFF,  4'b1111, 1'b0, 32'h0,         "wr_oor"});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h0,          4'b0000, 1'b1, 32'h0102_0304, "rd_0"});
    vecs.push_back('{1'b0, 32'h0000_0103, 32'h0,          4'b0000, 1'b1, 32'hDEAD_BEEF, "rd_unal"});

    // Contention from reset: both masters request continuously.
    drive(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 32'h0000_0000, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_sram_en", {31'b0, sram_en}, 32'd0);
    check("rst_sram_we", {28'b0, sram_we}, 32'd0);
    check("rst_ready", {30'b0, m1_if.ready, m0_if.ready}, 32'd0);
    check("rst_rdata", m0_if.rdata | m1_if.rdata, 32'd0);
    check("rst_cons", {31'b0, cons_valid}, 32'd0);
    sb_q.push_back('{1'b0, 32'hDEAD_BEEF});
    sb_q.push_back('{1'b1, 32'h0102_0304});
    sb_q.push_back('{1'b0, 32'hDEAD_BEEF});
    sb_q.push_back('{1'b1, 32'h0102_0304});
    resetn = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 4; c++) begin
      @(posedge clk); #1;
      if (m0_if.ready || m1_if.ready) cnt++;
    end
    check("contention_count", cnt, 32'd4);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check("contention_idle", {31'b0, busy}, 32'd0);
    check("contention_sb_empty", sb_q.size(), 32'd0);

    for (int i = 0; i < vecs.size(); i++)
      txn(vecs[i].m, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
          vecs[i].exp_en, vecs[i].exp_rd, 1'b0, vecs[i].name);

    txn(1'b0, 32'h1000_0000, 32'h0000_0041, 4'b0001, 1'b0, 32'h0, CONS_EN, "cons_wr");
    txn(1'b0, 32'h1000_0000, 32'h0,         4'b0000, 1'b0, 32'h0, 1'b0,    "cons_rd");

    // Reset during ACCESS of an m1 write; pointer must come back favouring m0.
    txn(1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b0, "pre_rst");
    drive(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'b1111);
    @(posedge clk); #1;
    check("midrst_grant_m1", {31'b0, sram_en, 14'b0, sram_addr}, {31'b1, 14'b0, 14'h0080});
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_sram_en", {31'b0, sram_en}, 32'd0);
    check("midrst_sram_we", {28'b0, sram_we}, 32'd0);
    check("midrst_ready", {30'b0, m1_if.ready, m0_if.ready}, 32'd0);
    resetn = 1'b1;
    sb_q.push_back('{1'b0, 32'hDEAD_BEEF});
    sb_q.push_back('{1'b1, 32'h0});
    @(posedge clk); #1;
    check("postrst_grant_m0", {18'b0, sram_addr}, 32'h40);
    @(posedge clk); #1;
    check("postrst_ready_m0", {30'b0, m1_if.ready, m0_if.ready}, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check("postrst_idle", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check("postrst_m1_kept", {31'b0, sram_en, 14'b0, sram_addr}, {31'b1, 14'b0, 14'h0080});
    @(posedge clk); #1;
    check("postrst_ready_m1", {30'b0, m1_if.ready, m0_if.ready}, 32'd2);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check("final_sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
